// File: rtl/led_pwm_controller.sv
// LED array driver: global PWM dimming, per-LED blink and selectable pin polarity.
// Every output is registered; loads take effect on the edge that samples them.
module led_pwm_controller #(
    parameter int N_LEDS        = 36,
    parameter int PWM_BITS      = 4,
    parameter int PRESCALE      = 256,
    parameter int BLINK_PERIODS = 64,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                en,
    input  logic                frame_ld,
    input  logic [N_LEDS-1:0]   frame_data,
    input  logic [N_LEDS-1:0]   blink_mask,
    input  logic                bright_ld,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                period_strobe,
    output logic [N_LEDS-1:0]   out_to_led
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [BL_W-1:0]   BL_LAST = BL_W'(BLINK_PERIODS - 1);
    localparam logic              OFF_BIT = (ACTIVE_LOW != 0);
    localparam logic [N_LEDS-1:0] OFF_LVL = {N_LEDS{OFF_BIT}};

    logic [N_LEDS-1:0]   frame_q, frame_d;
    logic [N_LEDS-1:0]   mask_q, mask_d;
    logic [PWM_BITS-1:0] bright_stg_q, bright_stg_d;
    logic [PWM_BITS-1:0] bright_act_q, bright_act_d;
    logic [PS_W-1:0]     presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic                en_q, en_d;
    logic                strobe_q, strobe_d;
    logic [N_LEDS-1:0]   out_q, out_d;

    logic                tick;
    logic                wrap;
    logic [N_LEDS-1:0]   lit;

    // Loads have no handshake: frame_ld (when en) and bright_ld are taken on
    // the sampling edge, every cycle, with no backpressure.
    always_comb begin
        tick          = en && (presc_q == PS_LAST);
        wrap          = tick && (pwm_cnt_q == '1);

        frame_d       = frame_q;
        mask_d        = mask_q;
        bright_stg_d  = bright_stg_q;
        bright_act_d  = bright_act_q;
        presc_d       = presc_q;
        pwm_cnt_d     = pwm_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        en_d          = en;
        strobe_d      = wrap;

        if (en && frame_ld) begin
            frame_d = frame_data;
            mask_d  = blink_mask;
        end

        if (bright_ld) begin
            bright_stg_d = brightness;
        end

        // Duty only changes at a period boundary, or freely while disabled.
        if (!en || wrap) begin
            bright_act_d = bright_stg_q;
        end

        if (!en) begin
            presc_d       = '0;
            pwm_cnt_d     = '0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else begin
            presc_d = tick ? '0 : presc_q + PS_W'(1);
            if (tick) begin
                pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
            end
            if (wrap) begin
                if (blink_cnt_q == BL_LAST) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BL_W'(1);
                end
            end
        end

        lit   = {N_LEDS{en_q}} & frame_q & {N_LEDS{pwm_cnt_q < bright_act_q}}
              & ~(mask_q & {N_LEDS{blink_phase_q}});
        out_d = lit ^ OFF_LVL;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            frame_q       <= '0;
            mask_q        <= '0;
            bright_stg_q  <= '1;
            bright_act_q  <= '1;
            presc_q       <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            en_q          <= 1'b0;
            strobe_q      <= 1'b0;
            out_q         <= OFF_LVL;
        end else begin
            frame_q       <= frame_d;
            mask_q        <= mask_d;
            bright_stg_q  <= bright_stg_d;
            bright_act_q  <= bright_act_d;
            presc_q       <= presc_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            en_q          <= en_d;
            strobe_q      <= strobe_d;
            out_q         <= out_d;
        end
    end

    assign period_strobe = strobe_q;
    assign out_to_led    = out_q;

endmodule

// File: tb/tb_led_pwm_controller.sv
// Directed bench for led_pwm_controller: an arithmetic model predicts every cycle,
// plus hand-counted duty/blink/latency figures that pin the model.
module tb_led_pwm_controller;

    localparam int N   = 36;
    localparam int B   = 2;
    localparam int P   = 2;
    localparam int BP  = 2;
    localparam int PER = P * (1 << B);
    localparam int W   = N + 1;
    localparam logic [N-1:0] ALL_OFF = '1;

    logic         clk = 1'b0;
    logic         rst_l = 1'b0;
    logic         en = 1'b0;
    logic         frame_ld = 1'b0;
    logic         bright_ld = 1'b0;
    logic [N-1:0] frame_data = '0;
    logic [N-1:0] blink_mask = '0;
    logic [B-1:0] brightness = '0;
    logic         period_strobe;
    logic [N-1:0] out_to_led;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // model state
    logic [N-1:0] m_frame, m_mask;
    logic [B-1:0] m_stg, m_act;
    int           m_n;
    logic         m_en_q;

    led_pwm_controller #(
        .N_LEDS(N), .PWM_BITS(B), .PRESCALE(P), .BLINK_PERIODS(BP), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_l(rst_l), .en(en), .frame_ld(frame_ld),
        .frame_data(frame_data), .blink_mask(blink_mask),
        .bright_ld(bright_ld), .brightness(brightness),
        .period_strobe(period_strobe), .out_to_led(out_to_led)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // n = consecutive enabled edges; all timing is derived from it arithmetically.
    task automatic model_step();
        int pwm, phase;
        logic [N-1:0] lit;
        logic wrap_now;
        if (!rst_l) begin
            m_frame = '0; m_mask = '0; m_stg = '1; m_act = '1;
            m_n = 0; m_en_q = 1'b0;
            exp_q.delete();
        end else begin
            pwm   = (m_n / P) % (1 << B);
            phase = ((m_n / PER) / BP) % 2;
            lit   = '0;
            if (m_en_q && (pwm < int'(m_act)))
                lit = m_frame & ~((phase == 1) ? m_mask : '0);
            wrap_now = en && (((m_n + 1) % PER) == 0);
            if (!en || wrap_now) m_act = m_stg;
            if (bright_ld) m_stg = brightness;
            if (en && frame_ld) begin
                m_frame = frame_data;
                m_mask  = blink_mask;
            end
            m_n    = en ? m_n + 1 : 0;
            m_en_q = en;
            exp_q.push_back({wrap_now, ~lit});
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_l);
            model_step();
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_l || exp_q.size() == 0) e = {1'b0, ALL_OFF};
            else e = exp_q.pop_front();
            check("cycle_outputs", 64'({period_strobe, out_to_led}), 64'(e));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_frame(input logic [N-1:0] d, input logic [N-1:0] m);
        @(negedge clk);
        frame_data = d; blink_mask = m; frame_ld = 1'b1;
        @(negedge clk);
        frame_ld = 1'b0;
    endtask

    task automatic load_bright(input logic [B-1:0] b);
        @(negedge clk);
        brightness = b; bright_ld = 1'b1;
        @(negedge clk);
        bright_ld = 1'b0;
    endtask

    task automatic load_both(input logic [N-1:0] d, input logic [N-1:0] m, input logic [B-1:0] b);
        @(negedge clk);
        frame_data = d; blink_mask = m; frame_ld = 1'b1;
        brightness = b; bright_ld = 1'b1;
        @(negedge clk);
        frame_ld = 1'b0; bright_ld = 1'b0;
    endtask

    task automatic wait_strobe();
        int k;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (period_strobe) break;
            k++;
        end
        check("wait_strobe_timeout", 64'(k < 100), 64'(1));
    endtask

    task automatic count_win(input int idx, input int cycles, output int lows, output int strobes);
        lows = 0; strobes = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (!out_to_led[idx]) lows++;
            if (period_strobe) strobes++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lows, strb, k;

        // 1: reset and disabled idle
        #12;
        check("reset_out", 64'(out_to_led), 64'(36'hF_FFFF_FFFF));
        check("reset_strobe", 64'(period_strobe), 64'(0));
        @(negedge clk);
        rst_l = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_en0_out", 64'(out_to_led), 64'(36'hF_FFFF_FFFF));

        // 2: single LED at reset brightness (3 of 4 steps lit)
        @(negedge clk);
        en = 1'b1;
        load_frame(36'h0_0000_0001, '0);
        wait_strobe();
        count_win(0, 8, lows, strb);
        check("duty3_bit0_lows", 64'(lows), 64'(6));
        check("duty3_strobes", 64'(strb), 64'(1));
        count_win(1, 8, lows, strb);
        check("duty3_bit1_lows", 64'(lows), 64'(0));

        // 3: mid-period brightness change, then zero, then load on a wrap edge
        repeat (3) @(negedge clk);
        load_bright(2);
        wait_strobe();
        count_win(0, 8, lows, strb);
        check("duty2_bit0_lows", 64'(lows), 64'(4));
        load_bright(0);
        wait_strobe();
        count_win(0, 16, lows, strb);
        check("duty0_bit0_lows", 64'(lows), 64'(0));
        check("duty0_strobes", 64'(strb), 64'(2));
        wait_strobe();
        repeat (6) @(negedge clk);
        load_bright(1);
        count_win(0, 8, lows, strb);
        check("wrap_load_held_lows", 64'(lows), 64'(0));
        wait_strobe();
        count_win(0, 8, lows, strb);
        check("wrap_load_applied_lows", 64'(lows), 64'(2));

        // 4: blink on bit0, steady bit1, simultaneous frame and brightness load
        load_both(36'h0_0000_0003, 36'h0_0000_0001, 3);
        wait_strobe();
        wait_strobe();
        count_win(0, 32, lows, strb);
        check("blink_bit0_lows", 64'(lows), 64'(12));
        check("blink_strobes", 64'(strb), 64'(4));
        count_win(1, 32, lows, strb);
        check("blink_bit1_lows", 64'(lows), 64'(24));

        // 5: disable, ignored load, re-enable restarts counters
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("disabled_out", 64'(out_to_led), 64'(36'hF_FFFF_FFFF));
        load_frame(36'h0_0000_0004, '0);
        @(negedge clk);
        en = 1'b1;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            k++;
            if (period_strobe) break;
        end
        check("reenable_first_strobe", 64'(k), 64'(8));
        count_win(1, 8, lows, strb);
        check("reenable_bit1_lows", 64'(lows), 64'(6));
        count_win(2, 8, lows, strb);
        check("ignored_bit2_lows", 64'(lows), 64'(0));

        // 6: asynchronous reset mid-blink
        repeat (13) @(negedge clk);
        #2;
        rst_l = 1'b0;
        #1;
        check("async_reset_out", 64'(out_to_led), 64'(36'hF_FFFF_FFFF));
        check("async_reset_strobe", 64'(period_strobe), 64'(0));
        @(negedge clk);
        rst_l = 1'b1;
        repeat (4) @(negedge clk);
        count_win(0, 16, lows, strb);
        check("post_reset_bit0_lows", 64'(lows), 64'(0));
        check("post_reset_out", 64'(out_to_led), 64'(36'hF_FFFF_FFFF));

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
